// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA raster timing generator.
// Counts pixels/lines on each i_pix_en strobe and produces registered hsync, vsync,
// data-enable and frame-start, all aligned with the registered o_hcnt/o_vcnt.
// Optional build macro VGA_SYNC_GEN_FRAME_CNT_EN adds FRAME_W and o_frame_cnt,
// a wrapping frame counter that steps on the edge that raises o_frame_start.
module vga_sync_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int unsigned CNT_W    = 10
`ifdef VGA_SYNC_GEN_FRAME_CNT_EN
    ,
    parameter int unsigned FRAME_W  = 8
`endif
) (
    input  logic             clk,
    input  logic             i_sclr,
    input  logic             i_pix_en,
    output logic [CNT_W-1:0] o_hcnt,
    output logic [CNT_W-1:0] o_vcnt,
    output logic             o_hsync,
    output logic             o_vsync,
    output logic             o_de,
    output logic             o_frame_start
`ifdef VGA_SYNC_GEN_FRAME_CNT_EN
    ,
    output logic [FRAME_W-1:0] o_frame_cnt
`endif
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_MAX      = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_MAX      = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT_END  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_END  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START   = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END     = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START   = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END     = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [CNT_W-1:0] r_hcnt;
    logic [CNT_W-1:0] r_vcnt;
    logic             r_hsync;
    logic             r_vsync;
    logic             r_de;
    logic             r_frame_start;

    logic [CNT_W-1:0] w_hcnt_nxt;
    logic [CNT_W-1:0] w_vcnt_nxt;
    logic             w_hs_act;
    logic             w_vs_act;
    logic             w_de_nxt;
    logic             w_at_origin;

    // Next raster position for a strobe; decode runs on it so outputs align with counters
    always_comb begin
        w_hcnt_nxt = r_hcnt + 1'b1;
        w_vcnt_nxt = r_vcnt;
        if (r_hcnt == H_MAX) begin
            w_hcnt_nxt = '0;
            w_vcnt_nxt = (r_vcnt == V_MAX) ? '0 : r_vcnt + 1'b1;
        end
        w_de_nxt    = (w_hcnt_nxt < H_ACT_END) && (w_vcnt_nxt < V_ACT_END);
        w_hs_act    = (w_hcnt_nxt >= HS_START) && (w_hcnt_nxt < HS_END);
        w_vs_act    = (w_vcnt_nxt >= VS_START) && (w_vcnt_nxt < VS_END);
        w_at_origin = (w_hcnt_nxt == '0) && (w_vcnt_nxt == '0);
    end

    // Counter and decode registers; reset parks at the last pixel so the first strobe hits (0,0)
    always_ff @(posedge clk) begin
        if (i_sclr) begin
            r_hcnt        <= H_MAX;
            r_vcnt        <= V_MAX;
            r_de          <= 1'b0;
            r_hsync       <= ~HS_POL;
            r_vsync       <= ~VS_POL;
            r_frame_start <= 1'b0;
        end else if (i_pix_en) begin
            r_hcnt        <= w_hcnt_nxt;
            r_vcnt        <= w_vcnt_nxt;
            r_de          <= w_de_nxt;
            r_hsync       <= w_hs_act ? HS_POL : ~HS_POL;
            r_vsync       <= w_vs_act ? VS_POL : ~VS_POL;
            r_frame_start <= w_at_origin;
        end else begin
            r_frame_start <= 1'b0;
        end
    end

`ifdef VGA_SYNC_GEN_FRAME_CNT_EN
    logic [FRAME_W-1:0] r_frame_cnt;

    // Frame counter steps together with the frame-start pulse
    always_ff @(posedge clk) begin
        if (i_sclr) begin
            r_frame_cnt <= '0;
        end else if (i_pix_en && w_at_origin) begin
            r_frame_cnt <= r_frame_cnt + 1'b1;
        end
    end

    assign o_frame_cnt = r_frame_cnt;
`endif

    assign o_hcnt        = r_hcnt;
    assign o_vcnt        = r_vcnt;
    assign o_hsync       = r_hsync;
    assign o_vsync       = r_vsync;
    assign o_de          = r_de;
    assign o_frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Testbench for vga_sync_gen: a full-size 640x480 instance plus a tiny-raster instance
// (15x8 totals) that makes whole frames reachable in a short run. Stimulus pushes expected
// outputs into a queue; a monitor pops and compares one entry per clock.
module tb_vga_sync_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic i_sclr   = 1'b1;
    logic i_pix_en = 1'b0;

    logic [9:0] a_h, a_v;
    logic       a_hs, a_vs, a_de, a_fs;
    logic [3:0] b_h, b_v;
    logic       b_hs, b_vs, b_de, b_fs;
`ifdef VGA_SYNC_GEN_FRAME_CNT_EN
    logic [7:0] a_fc;
    logic [1:0] b_fc;
`endif

    vga_sync_gen u_a (
        .clk           (clk),
        .i_sclr        (i_sclr),
        .i_pix_en      (i_pix_en),
        .o_hcnt        (a_h),
        .o_vcnt        (a_v),
        .o_hsync       (a_hs),
        .o_vsync       (a_vs),
        .o_de          (a_de),
        .o_frame_start (a_fs)
`ifdef VGA_SYNC_GEN_FRAME_CNT_EN
        ,
        .o_frame_cnt   (a_fc)
`endif
    );

    vga_sync_gen #(
        .H_ACTIVE (8),
        .H_FP     (2),
        .H_SYNC   (3),
        .H_BP     (2),
        .V_ACTIVE (4),
        .V_FP     (1),
        .V_SYNC   (2),
        .V_BP     (1),
        .CNT_W    (4)
`ifdef VGA_SYNC_GEN_FRAME_CNT_EN
        ,
        .FRAME_W  (2)
`endif
    ) u_b (
        .clk           (clk),
        .i_sclr        (i_sclr),
        .i_pix_en      (i_pix_en),
        .o_hcnt        (b_h),
        .o_vcnt        (b_v),
        .o_hsync       (b_hs),
        .o_vsync       (b_vs),
        .o_de          (b_de),
        .o_frame_start (b_fs)
`ifdef VGA_SYNC_GEN_FRAME_CNT_EN
        ,
        .o_frame_cnt   (b_fc)
`endif
    );

    typedef struct {
        int h;
        int v;
        bit de;
        bit hs;
        bit vs;
        bit fs;
    } exp_t;

    typedef struct {
        exp_t a;
        exp_t b;
    } pair_t;

    pair_t q[$];
    pair_t mon_p;
    int    n_tests = 0;
    int    n_fail  = 0;
    int    ah = 0, av = 0, bh = 0, bv = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%h) expected %0d", name, act, act, exp);
        end
    endtask

    // Raster model written from the timing table: position steps, decode from position
    task automatic model_step(input bit sclr, input bit pe,
                              input int ha, input int hf, input int hsw, input int hb,
                              input int va, input int vf, input int vsw, input int vb,
                              inout int h, inout int v, output exp_t e);
        int ht;
        int vt;
        ht   = ha + hf + hsw + hb;
        vt   = va + vf + vsw + vb;
        e.fs = 1'b0;
        if (sclr) begin
            h = ht - 1;
            v = vt - 1;
        end else if (pe) begin
            if (h == ht - 1) begin
                h = 0;
                v = (v == vt - 1) ? 0 : v + 1;
            end else begin
                h = h + 1;
            end
            e.fs = (h == 0) && (v == 0);
        end
        e.h  = h;
        e.v  = v;
        e.de = (h < ha) && (v < va);
        e.hs = !((h >= ha + hf) && (h < ha + hf + hsw));
        e.vs = !((v >= va + vf) && (v < va + vf + vsw));
    endtask

    // Drive one clock of stimulus and queue what both instances must show after the edge
    task automatic step(input bit sclr, input bit pe);
        pair_t p;
        @(negedge clk);
        i_sclr   = sclr;
        i_pix_en = pe;
        model_step(sclr, pe, 640, 16, 96, 48, 480, 10, 2, 33, ah, av, p.a);
        model_step(sclr, pe, 8, 2, 3, 2, 4, 1, 2, 1, bh, bv, p.b);
        q.push_back(p);
        @(posedge clk);
        #2;
    endtask

    // Monitor: one expected entry per clock edge
    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            mon_p = q.pop_front();
            chk("a_hcnt", 32'(a_h), mon_p.a.h);
            chk("a_vcnt", 32'(a_v), mon_p.a.v);
            chk("a_de", 32'(a_de), 32'(mon_p.a.de));
            chk("a_hsync", 32'(a_hs), 32'(mon_p.a.hs));
            chk("a_vsync", 32'(a_vs), 32'(mon_p.a.vs));
            chk("a_frame_start", 32'(a_fs), 32'(mon_p.a.fs));
            chk("b_hcnt", 32'(b_h), mon_p.b.h);
            chk("b_vcnt", 32'(b_v), mon_p.b.v);
            chk("b_de", 32'(b_de), 32'(mon_p.b.de));
            chk("b_hsync", 32'(b_hs), 32'(mon_p.b.hs));
            chk("b_vsync", 32'(b_vs), 32'(mon_p.b.vs));
            chk("b_frame_start", 32'(b_fs), 32'(mon_p.b.fs));
        end
    end

    initial begin
        int de_cnt;
        int hs_cnt;
        int hs_min;
        int hs_max;
        int n_str;
        int last;
        int vs_cnt;
        bit pe;

        // Reset state
        repeat (3) step(1'b1, 1'b0);
        chk("rst_a_hcnt", 32'(a_h), 799);
        chk("rst_a_vcnt", 32'(a_v), 524);
        chk("rst_a_de", 32'(a_de), 0);
        chk("rst_a_hsync", 32'(a_hs), 1);
        chk("rst_a_vsync", 32'(a_vs), 1);
        chk("rst_a_fs", 32'(a_fs), 0);
        chk("rst_b_hcnt", 32'(b_h), 14);
        chk("rst_b_vcnt", 32'(b_v), 7);

        // First strobe lands on the origin, frame_start lasts one clock
        step(1'b0, 1'b1);
        chk("first_a_hcnt", 32'(a_h), 0);
        chk("first_a_vcnt", 32'(a_v), 0);
        chk("first_a_de", 32'(a_de), 1);
        chk("first_a_fs", 32'(a_fs), 1);
        chk("first_b_fs", 32'(b_fs), 1);
        step(1'b0, 1'b0);
        chk("hold_a_fs", 32'(a_fs), 0);
        chk("hold_a_hcnt", 32'(a_h), 0);
        chk("hold_a_de", 32'(a_de), 1);

        // First line at one strobe per clock
        step(1'b1, 1'b0);
        de_cnt = 0;
        hs_cnt = 0;
        hs_min = 9999;
        hs_max = -1;
        for (int i = 0; i < 800; i++) begin
            step(1'b0, 1'b1);
            if (a_de === 1'b1) de_cnt++;
            if (a_hs === 1'b0) begin
                hs_cnt++;
                if (int'(a_h) < hs_min) hs_min = int'(a_h);
                if (int'(a_h) > hs_max) hs_max = int'(a_h);
            end
        end
        chk("line_de_count", de_cnt, 640);
        chk("line_hs_count", hs_cnt, 96);
        chk("line_hs_first", hs_min, 656);
        chk("line_hs_last", hs_max, 751);
        chk("line_end_hcnt", 32'(a_h), 799);
        chk("line_end_vcnt", 32'(a_v), 0);
        step(1'b0, 1'b1);
        chk("line1_hcnt", 32'(a_h), 0);
        chk("line1_vcnt", 32'(a_v), 1);

        // Whole small frames with a strobe every 4th clock
        step(1'b1, 1'b0);
        n_str  = 0;
        last   = -1;
        vs_cnt = 0;
        for (int i = 0; i < 1444; i++) begin
            pe = (i % 4 == 0);
            step(1'b0, pe);
            if (pe) begin
                n_str++;
                if (b_vs === 1'b0) vs_cnt++;
            end
            if (b_fs === 1'b1) begin
                if (last >= 0) chk("b_frame_gap", n_str - last, 120);
                last = n_str;
            end
        end
        chk("b_last_fs_strobe", last, 361);
        chk("b_vsync_strobes", vs_cnt, 90);

        // Reset mid-line with a strobe in the same cycle
        step(1'b1, 1'b0);
        repeat (1101) step(1'b0, 1'b1);
        chk("mid_a_hcnt", 32'(a_h), 300);
        chk("mid_a_vcnt", 32'(a_v), 1);
        step(1'b1, 1'b1);
        chk("sclr_a_hcnt", 32'(a_h), 799);
        chk("sclr_a_vcnt", 32'(a_v), 524);
        chk("sclr_a_de", 32'(a_de), 0);
        chk("sclr_a_fs", 32'(a_fs), 0);
        step(1'b0, 1'b1);
        chk("resume_a_hcnt", 32'(a_h), 0);
        chk("resume_a_vcnt", 32'(a_v), 0);
        chk("resume_a_fs", 32'(a_fs), 1);

`ifdef VGA_SYNC_GEN_FRAME_CNT_EN
        begin
            int seq[5];
            int k;
            seq = '{1, 2, 3, 0, 1};
            k   = 0;
            step(1'b1, 1'b0);
            chk("fc_rst", 32'(b_fc), 0);
            for (int i = 0; i < 600; i++) begin
                step(1'b0, 1'b1);
                if (b_fs === 1'b1) begin
                    if (k < 5) chk("fc_seq", 32'(b_fc), seq[k]);
                    k++;
                end
            end
            chk("fc_frames", k, 5);
        end
`endif

        repeat (2) @(posedge clk);
        #2;
        chk("sb_drain", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
